// File: rtl/counter_pkg.sv
// Shared types for the up/down counter family: run modes and one-shot FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        OS_IDLE = 2'b00,
        OS_RUN  = 2'b01,
        OS_DONE = 2'b10
    } os_state_e;

endpackage

// File: rtl/counter_oneshot_fsm.sv
// One-shot sequencer: IDLE until a load, RUN until the bound is reached, then DONE.
module counter_oneshot_fsm
    import counter_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  mode_e     mode,
    input  logic      load,
    input  logic      clear,
    input  logic      en,
    input  logic      at_bound,
    input  logic      hit_bound,
    output os_state_e state,
    output logic      busy,
    output logic      done,
    output logic      run_en
);

    os_state_e state_q;
    logic      busy_q;
    logic      done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= OS_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clear || (mode != MODE_ONESHOT)) begin
            state_q <= OS_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                OS_IDLE: begin
                    if (load) begin
                        state_q <= OS_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                OS_RUN: begin
                    // Finish either on the step that lands on the bound or when already parked there.
                    if (!load && en && (at_bound || hit_bound)) begin
                        state_q <= OS_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                OS_DONE: begin
                    if (load) begin
                        state_q <= OS_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= OS_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign state  = state_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign run_en = (state_q == OS_RUN) && en && !at_bound;

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with wrap, saturate and one-shot modes plus load clamping.
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clear,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             sat,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] clamped;
    logic             at_bound;
    logic             hit_bound;
    logic             run_en;
    mode_e            mode_s;
    os_state_e        os_state;

    assign mode_s    = mode_e'(mode);
    assign at_bound  = up ? (count_q == MAX_C) : (count_q == '0);
    assign hit_bound = up ? (count_q == (MAX_C - ONE_C)) : (count_q == ONE_C);
    assign clamped   = (load_data > MAX_C) ? MAX_C : load_data;

    // Bound is tested before the add/subtract, so the result never needs a carry bit.
    always_comb begin
        stepped = count_q;
        if (up) begin
            stepped = (count_q == MAX_C) ? '0 : count_q + ONE_C;
        end else begin
            stepped = (count_q == '0) ? MAX_C : count_q - ONE_C;
        end
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = RST_C;
        end else if (load) begin
            count_d = clamped;
        end else if (en) begin
            case (mode_s)
                MODE_SAT: begin
                    if (!at_bound) begin
                        count_d = stepped;
                        tc_d    = hit_bound;
                    end
                end
                MODE_ONESHOT: begin
                    if (run_en) begin
                        count_d = stepped;
                        tc_d    = hit_bound;
                    end else if ((os_state == OS_RUN) && at_bound) begin
                        tc_d = 1'b1;
                    end
                end
                default: begin
                    count_d = stepped;
                    tc_d    = at_bound;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RST_C;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    counter_oneshot_fsm u_fsm (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode_s),
        .load      (load),
        .clear     (clear),
        .en        (en),
        .at_bound  (at_bound),
        .hit_bound (hit_bound),
        .state     (os_state),
        .busy      (busy),
        .done      (done),
        .run_en    (run_en)
    );

    assign count = count_q;
    assign tc    = tc_q;
    assign sat   = (mode_s == MODE_SAT) && at_bound;

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed vector bench for updown_counter_n (WIDTH=4, MAX_VAL=9) plus a MAX_VAL=15 clamp instance.
module tb_updown_counter_n;

    typedef struct {
        logic       clr;
        logic       ld;
        logic       en;
        logic       up;
        logic [1:0] mode;
        logic [3:0] data;
        logic [3:0] cnt;
        logic       tc;
        logic       sat;
        logic       done;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_data = 4'd0;
    logic       clear = 1'b0;
    logic [1:0] mode = 2'b00;

    logic [3:0] count, count15;
    logic       tc, sat, done, busy;
    logic       tc15, sat15, done15, busy15;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_data(load_data), .clear(clear), .mode(mode),
        .count(count), .tc(tc), .sat(sat), .done(done), .busy(busy)
    );

    updown_counter_n #(.WIDTH(4), .MAX_VAL(15), .RESET_VAL(0)) u_dut15 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_data(load_data), .clear(clear), .mode(mode),
        .count(count15), .tc(tc15), .sat(sat15), .done(done15), .busy(busy15)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic v(input logic clr, input logic ld, input logic e, input logic u,
                     input logic [1:0] m, input logic [3:0] d, input logic [3:0] c,
                     input logic t, input logic s, input logic dn, input logic b);
        vec_t r;
        r.clr = clr; r.ld = ld; r.en = e; r.up = u; r.mode = m; r.data = d;
        r.cnt = c; r.tc = t; r.sat = s; r.done = dn; r.busy = b;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic clr, input logic ld, input logic e, input logic u,
                         input logic [1:0] m, input logic [3:0] d);
        clear = clr; load = ld; en = e; up = u; mode = m; load_data = d;
    endtask

    task automatic check_outs(input string tag, input int c, input int t, input int s,
                              input int dn, input int b);
        chk({tag, "_count"}, int'(count), c);
        chk({tag, "_tc"},    int'(tc),    t);
        chk({tag, "_sat"},   int'(sat),   s);
        chk({tag, "_done"},  int'(done),  dn);
        chk({tag, "_busy"},  int'(busy),  b);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].mode, vecs[i].data);
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), int'(vecs[i].cnt), int'(vecs[i].tc),
                       int'(vecs[i].sat), int'(vecs[i].done), int'(vecs[i].busy));
        end
    endtask

    initial begin
        int split;

        // clr ld en up mode data | count tc sat done busy
        v(0,1,0,1,2'd0,4'd8,  4'd8,0,0,0,0);
        v(0,0,1,1,2'd0,4'd0,  4'd9,0,0,0,0);
        v(0,0,1,1,2'd0,4'd0,  4'd0,1,0,0,0);
        v(0,0,1,1,2'd0,4'd0,  4'd1,0,0,0,0);
        v(0,0,1,0,2'd0,4'd0,  4'd0,0,0,0,0);
        v(0,0,1,0,2'd0,4'd0,  4'd9,1,0,0,0);
        v(0,1,1,0,2'd1,4'd2,  4'd2,0,0,0,0);
        v(0,0,1,0,2'd1,4'd0,  4'd1,0,0,0,0);
        v(0,0,1,0,2'd1,4'd0,  4'd0,1,1,0,0);
        v(0,0,1,0,2'd1,4'd0,  4'd0,0,1,0,0);
        v(0,0,1,0,2'd1,4'd0,  4'd0,0,1,0,0);
        split = vecs.size();
        v(0,0,1,1,2'd1,4'd0,  4'd1,0,0,0,0);
        v(0,0,1,1,2'd1,4'd0,  4'd2,0,0,0,0);
        v(0,1,0,1,2'd1,4'd8,  4'd8,0,0,0,0);
        v(0,0,1,1,2'd1,4'd0,  4'd9,1,1,0,0);
        v(0,0,1,1,2'd1,4'd0,  4'd9,0,1,0,0);
        v(1,1,1,1,2'd0,4'd6,  4'd0,0,0,0,0);
        v(0,1,1,1,2'd0,4'd6,  4'd6,0,0,0,0);
        v(0,1,0,1,2'd0,4'd9,  4'd9,0,0,0,0);
        v(0,1,1,1,2'd0,4'd3,  4'd3,0,0,0,0);
        v(0,0,1,1,2'd2,4'd0,  4'd3,0,0,0,0);
        v(0,0,1,1,2'd2,4'd0,  4'd3,0,0,0,0);
        v(0,1,0,1,2'd2,4'd7,  4'd7,0,0,0,1);
        v(0,0,1,1,2'd2,4'd0,  4'd8,0,0,0,1);
        v(0,0,1,1,2'd2,4'd0,  4'd9,1,0,1,0);
        v(0,0,1,1,2'd2,4'd0,  4'd9,0,0,1,0);
        v(0,0,1,1,2'd2,4'd0,  4'd9,0,0,1,0);
        v(0,1,0,1,2'd2,4'd3,  4'd3,0,0,0,1);
        v(0,0,1,1,2'd2,4'd0,  4'd4,0,0,0,1);
        v(0,0,0,1,2'd0,4'd0,  4'd4,0,0,0,0);
        v(0,0,1,1,2'd2,4'd0,  4'd4,0,0,0,0);
        v(0,1,0,1,2'd2,4'd9,  4'd9,0,0,0,1);
        v(0,0,1,1,2'd2,4'd0,  4'd9,1,0,1,0);
        v(1,0,0,1,2'd2,4'd0,  4'd0,0,0,0,0);
        v(0,1,0,1,2'd3,4'd9,  4'd9,0,0,0,0);
        v(0,0,1,1,2'd3,4'd0,  4'd0,1,0,0,0);

        // Reset state, held across a couple of edges.
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst", 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        // Reset dropped between edges while a one-shot is running at 5.
        drive(0,1,0,1,2'd2,4'd4);
        @(posedge clk); #1;
        check_outs("os_ld4", 4, 0, 0, 0, 1);
        drive(0,0,1,1,2'd2,4'd0);
        @(posedge clk); #1;
        check_outs("os_run5", 5, 0, 0, 0, 1);
        reset_n = 1'b0;
        #2;
        check_outs("async_rst", 0, 0, 0, 0, 0);
        #1;
        reset_n = 1'b1;
        drive(0,0,1,1,2'd0,4'd0);
        @(posedge clk); #1;
        check_outs("resume", 1, 0, 0, 0, 0);

        run_range(0, split);

        // Direction reversal at the SAT bound: sat must fall before any edge.
        drive(0,0,1,1,2'd1,4'd0);
        #1;
        chk("sat_drop", int'(sat), 0);
        chk("sat_drop_count", int'(count), 0);

        run_range(split, vecs.size());

        // Load clamping on both parameterisations.
        drive(0,1,0,1,2'd0,4'd12);
        @(posedge clk); #1;
        chk("clamp12_m9", int'(count), 9);
        chk("clamp12_m15", int'(count15), 12);
        drive(0,1,0,1,2'd0,4'd15);
        @(posedge clk); #1;
        chk("clamp15_m9", int'(count), 9);
        chk("clamp15_m15", int'(count15), 15);
        chk("m15_tc", int'(tc15), 0);
        chk("m15_sat", int'(sat15), 0);
        chk("m15_done", int'(done15), 0);
        chk("m15_busy", int'(busy15), 0);
        drive(0,0,1,1,2'd0,4'd0);
        @(posedge clk); #1;
        chk("m15_wrap_count", int'(count15), 0);
        chk("m15_wrap_tc", int'(tc15), 1);
        chk("m9_wrap_count", int'(count), 0);
        chk("m9_wrap_tc", int'(tc), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
